// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// master: controller (drives enables/selects, reads OP and Zero).
// slave: datapath (drives OP from IR[31:26] and the ALU Zero flag).
interface multicycle_control_if;
   logic [5:0] OP;
   logic       Zero;
   logic       PCEn;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegDst;
   logic       MemtoReg;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] ALUOp;
   logic       PCSource;
   logic       InstrDone;
   logic       Illegal;
   logic [3:0] State;

   modport master (
      input  OP,
      input  Zero,
      output PCEn,
      output IorD,
      output MemRead,
      output MemWrite,
      output IRWrite,
      output RegDst,
      output MemtoReg,
      output RegWrite,
      output ALUSrcA,
      output ALUSrcB,
      output ALUOp,
      output PCSource,
      output InstrDone,
      output Illegal,
      output State
   );

   modport slave (
      output OP,
      output Zero,
      input  PCEn,
      input  IorD,
      input  MemRead,
      input  MemWrite,
      input  IRWrite,
      input  RegDst,
      input  MemtoReg,
      input  RegWrite,
      input  ALUSrcA,
      input  ALUSrcB,
      input  ALUOp,
      input  PCSource,
      input  InstrDone,
      input  Illegal,
      input  State
   );
endinterface

// File: rtl/multicycle_control.sv
// Moore FSM sequencing the multicycle MIPS datapath (fetch..write-back).
// Ports: clk, reset (async, active-low), bus (control bundle, master).
// Macro MC_ILLEGAL_TRAP_EN: unsupported opcodes lock in TRAP until reset.
module multicycle_control (
   input  logic                        clk,
   input  logic                        reset,
   multicycle_control_if.master        bus
);

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      R_EXEC    = 4'd6,
      R_WB      = 4'd7,
      I_EXEC    = 4'd8,
      I_WB      = 4'd9,
      BRANCH    = 4'd10,
      TRAP      = 4'd11
   } state_t;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_ORI  = 6'h0d;
   localparam logic [5:0] OP_LUI  = 6'h0f;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2b;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;

   localparam logic [2:0] ALU_FUNCT = 3'b111;
   localparam logic [2:0] ALU_ADD   = 3'b100;
   localparam logic [2:0] ALU_OR    = 3'b101;
   localparam logic [2:0] ALU_LUI   = 3'b011;
   localparam logic [2:0] ALU_SUB   = 3'b001;

   state_t     state;
   state_t     next;

   logic       pc_en;
   logic       iord;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_op;
   logic       pc_source;
   logic       instr_done;
   logic       illegal;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= FETCH;
      end else begin
         state <= next;
      end
   end

   always_comb begin
      next       = FETCH;
      pc_en      = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 3'b000;
      pc_source  = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;

      case (state)
         FETCH: begin
            next      = DECODE;
            mem_read  = 1'b1;
            ir_write  = 1'b1;
            alu_src_b = 2'b01;
            alu_op    = ALU_ADD;
            pc_en     = 1'b1;
         end

         DECODE: begin
            // Branch target is computed into ALUOut here.
            alu_src_b = 2'b11;
            alu_op    = ALU_ADD;
            case (bus.OP)
               OP_R:    next = R_EXEC;
               OP_ADDI,
               OP_ORI,
               OP_LUI:  next = I_EXEC;
               OP_LW,
               OP_SW:   next = MEM_ADDR;
               OP_BEQ,
               OP_BNE:  next = BRANCH;
`ifdef MC_ILLEGAL_TRAP_EN
               default: next = TRAP;
`else
               // PC already advanced in FETCH: plain 2-cycle NOP.
               default: next = FETCH;
`endif
            endcase
         end

         MEM_ADDR: begin
            next      = (bus.OP == OP_LW) ? MEM_READ : MEM_WRITE;
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = ALU_ADD;
         end

         MEM_READ: begin
            next     = MEM_WB;
            iord     = 1'b1;
            mem_read = 1'b1;
         end

         MEM_WB: begin
            next       = FETCH;
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end

         MEM_WRITE: begin
            next       = FETCH;
            iord       = 1'b1;
            mem_write  = 1'b1;
            instr_done = 1'b1;
         end

         R_EXEC: begin
            next      = R_WB;
            alu_src_a = 1'b1;
            alu_op    = ALU_FUNCT;
         end

         R_WB: begin
            next       = FETCH;
            reg_dst    = 1'b1;
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end

         I_EXEC: begin
            next      = I_WB;
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            case (bus.OP)
               OP_ORI:  alu_op = ALU_OR;
               OP_LUI:  alu_op = ALU_LUI;
               default: alu_op = ALU_ADD;
            endcase
         end

         I_WB: begin
            next       = FETCH;
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end

         BRANCH: begin
            next       = FETCH;
            alu_src_a  = 1'b1;
            alu_op     = ALU_SUB;
            pc_source  = 1'b1;
            instr_done = 1'b1;
            pc_en      = (bus.OP == OP_BEQ) ? bus.Zero : ~bus.Zero;
         end

`ifdef MC_ILLEGAL_TRAP_EN
         TRAP: begin
            next    = TRAP;
            illegal = 1'b1;
         end
`endif

         // Encodings 12-15 (and TRAP when disabled): recover via FETCH.
         default: begin
            next = FETCH;
         end
      endcase
   end

   // Every strobe is held low for as long as reset is asserted.
   assign bus.PCEn      = reset & pc_en;
   assign bus.IorD      = reset & iord;
   assign bus.MemRead   = reset & mem_read;
   assign bus.MemWrite  = reset & mem_write;
   assign bus.IRWrite   = reset & ir_write;
   assign bus.RegDst    = reset & reg_dst;
   assign bus.MemtoReg  = reset & mem_to_reg;
   assign bus.RegWrite  = reset & reg_write;
   assign bus.ALUSrcA   = reset & alu_src_a;
   assign bus.ALUSrcB   = reset ? alu_src_b : 2'b00;
   assign bus.ALUOp     = reset ? alu_op : 3'b000;
   assign bus.PCSource  = reset & pc_source;
   assign bus.InstrDone = reset & instr_done;
   assign bus.Illegal   = reset & illegal;
   assign bus.State     = reset ? state : 4'd0;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control.
// Expected per-cycle output vectors are queued by stimulus, checked at negedge.
module tb_multicycle_control;

   logic clk;
   logic reset;

   multicycle_control_if bus ();

   multicycle_control dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // {State, PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
   //  RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, InstrDone, Illegal}
   typedef logic [20:0] vec_t;

   vec_t expq[$];
   int   checks = 0;
   int   errors = 0;

`ifdef MC_ILLEGAL_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   function automatic bit is_legal(input logic [5:0] op);
      return op inside {6'h00, 6'h08, 6'h0d, 6'h0f,
                        6'h23, 6'h2b, 6'h04, 6'h05};
   endfunction

   function automatic vec_t dut_vec();
      return {bus.State, bus.PCEn, bus.IorD, bus.MemRead, bus.MemWrite,
              bus.IRWrite, bus.RegDst, bus.MemtoReg, bus.RegWrite,
              bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource,
              bus.InstrDone, bus.Illegal};
   endfunction

   // Output table by state, as written in the controller description.
   function automatic vec_t model(input int st, input logic [5:0] op,
                                  input logic z);
      logic [3:0] s;
      logic pe, id, mr, mw, ir, rd, m2r, rw, sa, pcs, dn, il;
      logic [1:0] sb;
      logic [2:0] ao;
      s = st[3:0];
      {pe, id, mr, mw, ir, rd, m2r, rw, sa, pcs, dn, il} = '0;
      sb = 2'b00;
      ao = 3'b000;
      case (st)
         0:  begin mr = 1; ir = 1; sb = 2'b01; ao = 3'b100; pe = 1; end
         1:  begin sb = 2'b11; ao = 3'b100; end
         2:  begin sa = 1; sb = 2'b10; ao = 3'b100; end
         3:  begin id = 1; mr = 1; end
         4:  begin m2r = 1; rw = 1; dn = 1; end
         5:  begin id = 1; mw = 1; dn = 1; end
         6:  begin sa = 1; ao = 3'b111; end
         7:  begin rd = 1; rw = 1; dn = 1; end
         8:  begin
            sa = 1; sb = 2'b10;
            ao = (op == 6'h0d) ? 3'b101 :
                 (op == 6'h0f) ? 3'b011 : 3'b100;
         end
         9:  begin rw = 1; dn = 1; end
         10: begin
            sa = 1; ao = 3'b001; pcs = 1; dn = 1;
            pe = (op == 6'h04) ? z : ~z;
         end
         11: begin il = 1; end
         default: ;
      endcase
      return {s, pe, id, mr, mw, ir, rd, m2r, rw, sa, sb, ao, pcs, dn, il};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b0;
      for (int i = 0; i < n; i++) begin
         expq.push_back('0);
         tick();
      end
      reset = 1'b1;
   endtask

   // zmode: 0/1 hold Zero at that value, 2 randomize every cycle.
   task automatic run_instr(input logic [5:0] op, input int zmode);
      int   sts[$];
      logic z;
      case (op)
         6'h23:               sts = '{0, 1, 2, 3, 4};
         6'h2b:               sts = '{0, 1, 2, 5};
         6'h00:               sts = '{0, 1, 6, 7};
         6'h08, 6'h0d, 6'h0f: sts = '{0, 1, 8, 9};
         6'h04, 6'h05:        sts = '{0, 1, 10};
         default: begin
            sts = '{0, 1};
            if (TRAP_EN) begin
               for (int k = 0; k < 12; k++) sts.push_back(11);
            end
         end
      endcase
      bus.OP = op;
      foreach (sts[i]) begin
         z = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
         bus.Zero = z;
         expq.push_back(model(sts[i], op, z));
         tick();
      end
      if (!is_legal(op) && TRAP_EN) do_reset(2);
   endtask

   // Load aborted by reset while in MEM_READ.
   task automatic abort_lw();
      bus.OP   = 6'h23;
      bus.Zero = 1'b0;
      for (int s = 0; s < 3; s++) begin
         expq.push_back(model(s, 6'h23, 1'b0));
         tick();
      end
      do_reset(4);
   endtask

   always @(negedge clk) begin
      vec_t e;
      vec_t a;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         a = dut_vec();
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL cycle_vec exp_state=%0d actual=%h required=%h",
                     e[20:17], a, e);
         end
      end
   end

   initial begin
      logic [5:0] legal_ops [8];
      logic [5:0] op;
      legal_ops = '{6'h00, 6'h08, 6'h0d, 6'h0f,
                    6'h23, 6'h2b, 6'h04, 6'h05};
      reset    = 1'b0;
      bus.OP   = 6'h00;
      bus.Zero = 1'b0;
      tick();
      do_reset(3);

      abort_lw();
      run_instr(6'h23, 2);
      run_instr(6'h2b, 2);
      run_instr(6'h04, 1);
      run_instr(6'h04, 0);
      run_instr(6'h05, 1);
      run_instr(6'h05, 0);
      run_instr(6'h0d, 2);
      run_instr(6'h0f, 2);
      run_instr(6'h08, 2);
      run_instr(6'h00, 2);
      run_instr(6'h3f, 2);

      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            do op = 6'($urandom_range(0, 63)); while (is_legal(op));
         end else begin
            op = legal_ops[$urandom_range(0, 7)];
         end
         run_instr(op, 2);
         if ($urandom_range(0, 19) == 0) abort_lw();
      end

      @(negedge clk);
      #1;
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL queue_drain actual=%0d required=0", expq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style finite-state controller for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and write-back cycles, and drives the shared memory, IR, register-file, ALU-mux and PC enables. It takes the opcode from the instruction register and the ALU zero flag. Its ALUOp encoding matches the existing ALU control decoder.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-low; forces state FETCH
- `OP`  in  6  opcode from IR[31:26]; stable from DECODE until the next FETCH
- `Zero`  in  1  ALU zero flag; sampled combinationally in BRANCH
- `PCEn`  out  1  PC load enable (unconditional or branch-qualified)
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `MemRead`  out  1  memory read strobe
- `MemWrite`  out  1  memory write strobe
- `IRWrite`  out  1  instruction register load
- `RegDst`  out  1  destination select: 1 = rd, 0 = rt
- `MemtoReg`  out  1  write-back data select: 1 = MDR, 0 = ALUOut
- `RegWrite`  out  1  register-file write enable
- `ALUSrcA`  out  1  ALU A select: 0 = PC, 1 = register A
- `ALUSrcB`  out  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- `ALUOp`  out  3  ALU op code: 111 = R-type/funct, 100 = add, 101 = or, 011 = lui, 001 = subtract/compare
- `PCSource`  out  1  PC source: 0 = ALU result, 1 = ALUOut (branch target)
- `InstrDone`  out  1  one-cycle pulse in the final state of each instruction
- `Illegal`  out  1  unsupported opcode detected (see Configuration)
- `State`  out  4  current state encoding, for debug

## Operation
State encodings:
- FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4, MEM_WRITE = 5, R_EXEC = 6, R_WB = 7, I_EXEC = 8, I_WB = 9, BRANCH = 10, TRAP = 11
- Encodings 12–15 go to FETCH on the next edge, with all outputs 0.

Transitions:
- FETCH → DECODE
- DECODE, by OP:
  - 0x00 → R_EXEC
  - 0x08, 0x0d, 0x0f → I_EXEC
  - 0x23, 0x2b → MEM_ADDR
  - 0x04, 0x05 → BRANCH
  - any other opcode → illegal handling (see Configuration)
- MEM_ADDR → MEM_READ if OP = 0x23, else MEM_WRITE
- MEM_READ → MEM_WB
- R_EXEC → R_WB
- I_EXEC → I_WB
- MEM_WB, MEM_WRITE, R_WB, I_WB, BRANCH → FETCH

Outputs per state (any output not listed is 0):
- FETCH: MemRead = 1, IRWrite = 1, ALUSrcB = 01, ALUOp = 100, PCEn = 1
- DECODE: ALUSrcB = 11, ALUOp = 100 (branch target computed into ALUOut)
- MEM_ADDR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 100
- MEM_READ: IorD = 1, MemRead = 1
- MEM_WB: MemtoReg = 1, RegWrite = 1, InstrDone = 1
- MEM_WRITE: IorD = 1, MemWrite = 1, InstrDone = 1
- R_EXEC: ALUSrcA = 1, ALUOp = 111
- R_WB: RegDst = 1, RegWrite = 1, InstrDone = 1
- I_EXEC: ALUSrcA = 1, ALUSrcB = 10; ALUOp = 100 for 0x08, 101 for 0x0d, 011 for 0x0f
- I_WB: RegWrite = 1, InstrDone = 1
- BRANCH: ALUSrcA = 1, ALUOp = 001, PCSource = 1, InstrDone = 1; PCEn = Zero for 0x04, PCEn = ~Zero for 0x05

## Timing
Reset:
- While `reset` = 0: state = FETCH and `State` = 0.
- While `reset` = 0, all outputs are 0, including PCEn, IRWrite and MemRead. This gating applies for the whole time reset is low, not only at assertion.
- On the first rising edge after release, FETCH outputs take effect.
- Reset asserted mid-instruction aborts it immediately, with no further writes.

Latency (cycles, FETCH to FETCH):
- LW: 5
- SW, R-type, ADDI, ORI, LUI: 4
- BEQ, BNE: 3

Other rules:
- The only combinational inputs to outputs are `Zero` (BRANCH state only) and `OP` (I_EXEC ALUOp, BRANCH PCEn).
- InstrDone is exactly one cycle per retired instruction and is never asserted in TRAP.
- There is no handshake; memory is assumed single-cycle.

## Configuration
The unsupported-opcode trap is selected by macro `MC_ILLEGAL_TRAP_EN`.

With `MC_ILLEGAL_TRAP_EN` defined:
- An unsupported opcode in DECODE → TRAP.
- TRAP is terminal until `reset` = 0. In TRAP, Illegal = 1 and all other outputs are 0.

Without `MC_ILLEGAL_TRAP_EN`:
- An unsupported opcode in DECODE → FETCH, executing as a 2-cycle NOP (PC already advanced in FETCH).
- Illegal is tied to 0 and TRAP is unreachable.

## Test plan
- Reset low mid-MEM_READ, then released: State = 0 and all outputs = 0 while low; first edge after release: PCEn = 1, IRWrite = 1.
- OP = 0x23 from reset: states 0, 1, 2, 3, 4; RegWrite = 1 and MemtoReg = 1 in cycle 5; InstrDone pulses once.
- OP = 0x2b: states 0, 1, 2, 5; MemWrite = 1 and IorD = 1 in cycle 4; RegWrite stays 0 throughout.
- OP = 0x04 with Zero = 1, then with Zero = 0: PCEn in BRANCH = 1, then 0. OP = 0x05 gives the inverse. PCSource = 1 and ALUOp = 001 in all cases.
- OP = 0x0d and OP = 0x0f: ALUOp in I_EXEC = 101 and 011 respectively; RegDst = 0 and RegWrite = 1 in I_WB.
- OP = 0x3f:
  - with `MC_ILLEGAL_TRAP_EN`: State = 11 and Illegal = 1, held for 10+ cycles until reset.
  - without it: back to State = 0 after 2 cycles, Illegal = 0.
